// File: rtl/uart_burst_pkg.sv
// Shared constants and FSM encoding for the burst-capable UART cores.
package uart_burst_pkg;

  localparam int DIV_W_DEF      = 9;
  localparam int BYTES_PER_WORD = 4;
  localparam int MIN_DIV        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, mid-bit baud counter, FSM and shift register.
module uart_rx_byte
  import uart_burst_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divider,
  output logic [7:0]       rx_byte,
  output logic             byte_ok,
  output logic             frame_err,
  output logic             start,
  output logic             active,
  output logic [DIV_W-1:0] div_eff
);

  rx_state_e        state_q, state_d;
  logic             rxd_meta_q, rxd_s_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic [DIV_W-1:0] div_in;

  assign div_in  = (divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divider;
  assign rx_byte = shift_q;
  assign active  = (state_q != ST_IDLE);
  assign div_eff = div_q;

  // Synchroniser and receiver state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(MIN_DIV);
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      armed_q    <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
    end
  end

  // armed_q blocks a new start until the line has been seen high again
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rxd_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          start   = 1'b1;
          armed_d = 1'b0;
          div_d   = div_in;
          cnt_d   = div_in >> 1;
          state_d = ST_START;
        end else begin
          armed_d = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            armed_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = div_q;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          cnt_d   = div_q;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (rxd_s_q) begin
            byte_ok = 1'b1;
            armed_d = 1'b1;
          end else begin
            frame_err = 1'b1;
            armed_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_burst_rx.sv
// Burst-capable UART receiver: byte or little-endian 32-bit word delivery with sticky flags.
module uart_burst_rx
  import uart_burst_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int TO_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divider,
  input  logic             mode,
  input  logic             rd,
  output logic [31:0]      q,
  output logic             dv,
  output logic             ovf,
  output logic             ferr,
  output logic             tout,
  output logic             busy
);

  localparam int TO_W = $clog2(TO_BITS + 1);

  logic [7:0]       rx_byte;
  logic             byte_ok, frame_err, start, active;
  logic [DIV_W-1:0] div_eff;

  logic [31:0]      q_q, q_d;
  logic             dv_q, dv_d, ovf_q, ovf_d, ferr_q, ferr_d, tout_q, tout_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      asm_q, asm_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             commit;
  logic [31:0]      word;

  uart_rx_byte #(.DIV_W(DIV_W)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .divider   (divider),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .frame_err (frame_err),
    .start     (start),
    .active    (active),
    .div_eff   (div_eff)
  );

  assign q    = q_q;
  assign dv   = dv_q;
  assign ovf  = ovf_q;
  assign ferr = ferr_q;
  assign tout = tout_q;
  assign busy = active | (idx_q != 2'd0);

  // Word, flag and burst-assembly registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= 32'd0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      tout_q <= 1'b0;
      idx_q  <= 2'd0;
      asm_q  <= 24'd0;
      mode_q <= 1'b0;
      pre_q  <= '0;
      to_q   <= '0;
    end else begin
      q_q    <= q_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
      tout_q <= tout_d;
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      mode_q <= mode_d;
      pre_q  <= pre_d;
      to_q   <= to_d;
    end
  end

  // New events are applied after the rd clear so a same-cycle event wins
  always_comb begin
    q_d    = q_q;
    dv_d   = dv_q;
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    tout_d = tout_q;
    idx_d  = idx_q;
    asm_d  = asm_q;
    mode_d = mode_q;
    pre_d  = pre_q;
    to_d   = to_q;
    commit = 1'b0;
    word   = 32'd0;

    if (rd) begin
      dv_d   = 1'b0;
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
      tout_d = 1'b0;
    end else begin
      dv_d = dv_q;
    end

    if (start && (idx_q == 2'd0)) begin
      mode_d = mode;
    end else begin
      mode_d = mode_q;
    end

    if (!active && mode_q && (idx_q != 2'd0)) begin
      if (pre_q == div_eff) begin
        pre_d = '0;
        if (to_q == TO_W'(TO_BITS - 1)) begin
          to_d   = '0;
          idx_d  = 2'd0;
          tout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else begin
      pre_d = '0;
      to_d  = '0;
    end

    if (frame_err) begin
      ferr_d = 1'b1;
      idx_d  = 2'd0;
    end else if (byte_ok) begin
      if (!mode_q) begin
        word   = {24'd0, rx_byte};
        commit = 1'b1;
      end else if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
        word   = {rx_byte, asm_q};
        commit = 1'b1;
        idx_d  = 2'd0;
      end else begin
        case (idx_q)
          2'd0:    asm_d[7:0]   = rx_byte;
          2'd1:    asm_d[15:8]  = rx_byte;
          default: asm_d[23:16] = rx_byte;
        endcase
        idx_d = idx_q + 2'd1;
      end
    end else begin
      commit = 1'b0;
    end

    if (commit) begin
      if (!dv_q || rd) begin
        q_d  = word;
        dv_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      q_d = q_q;
    end
  end

endmodule

// File: tb/tb_uart_burst_rx.sv
// Directed scoreboard bench for uart_burst_rx at divider=7 (8 clocks per bit).
module tb_uart_burst_rx;

  localparam int PER = 8;
  localparam int LAT = 79;

  logic        clk = 1'b0;
  logic        reset, rxd, mode, rd;
  logic [8:0]  divider;
  logic [31:0] q;
  logic        dv, ovf, ferr, tout, busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t_fall = 0;
  int          dv_rise = 0;
  logic        dv_prev = 1'b0;
  logic [31:0] sb[$];

  uart_burst_rx #(.DIV_W(9), .TO_BITS(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .divider (divider),
    .mode    (mode),
    .rd      (rd),
    .q       (q),
    .dv      (dv),
    .ovf     (ovf),
    .ferr    (ferr),
    .tout    (tout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // dv rising-edge timestamp, in posedge counts
  always @(negedge clk) begin
    if (dv && !dv_prev) dv_rise <= cyc;
    dv_prev <= dv;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (i == 0) t_fall = cyc;
      repeat (PER) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    int k;
    k = 0;
    while (dv !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_dv"}, {63'd0, dv}, 64'd1);
    tick();
  endtask

  task automatic chk_word(input string tag);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %0h, expected <scoreboard empty>", tag, q);
    end else begin
      e = sb.pop_front();
      chk(tag, {32'd0, q}, {32'd0, e});
    end
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; rd = 1'b0; mode = 1'b0; divider = 9'd7;
    repeat (3) tick();
    chk("reset_vals", {27'd0, q, dv, ovf, ferr, tout, busy}, 64'd0);
    reset = 1'b0;
    repeat (4) tick();

    // normal byte with latency
    sb.push_back(32'h0000_0041);
    send_byte(8'h41, 1'b1);
    wait_dv("norm");
    chk("norm_latency", 64'(dv_rise - t_fall), 64'(LAT));
    chk_word("norm_q");
    chk("norm_flags", {61'd0, ovf, ferr, tout}, 64'd0);
    pulse_rd();
    chk("norm_rd_dv", {63'd0, dv}, 64'd0);

    // burst loopback
    mode = 1'b1;
    sb.push_back(32'h4443_4241);
    send_byte(8'h41, 1'b1);
    chk("burst_busy_mid", {63'd0, busy}, 64'd1);
    chk("burst_no_dv", {63'd0, dv}, 64'd0);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_dv("burst");
    chk_word("burst_q");
    chk("burst_busy_end", {63'd0, busy}, 64'd0);
    pulse_rd();
    mode = 1'b0;

    // overrun
    sb.push_back(32'h0000_0041);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_dv("ovr");
    chk_word("ovr_q");
    chk("ovr_flag", {63'd0, ovf}, 64'd1);
    pulse_rd();
    chk("ovr_rd_clear", {62'd0, dv, ovf}, 64'd0);
    sb.push_back(32'h0000_005A);
    send_byte(8'h5A, 1'b1);
    wait_dv("ovr2");
    chk_word("ovr2_q");
    chk("ovr2_flag", {63'd0, ovf}, 64'd0);
    pulse_rd();

    // framing error
    send_byte(8'h55, 1'b0);
    rxd = 1'b1;
    repeat (2 * PER) tick();
    chk("ferr_set", {62'd0, ferr, dv}, 64'b10);
    sb.push_back(32'h0000_0033);
    send_byte(8'h33, 1'b1);
    wait_dv("ferr_next");
    chk_word("ferr_next_q");
    pulse_rd();
    chk("ferr_rd_clear", {63'd0, ferr}, 64'd0);

    // 2-clock glitch
    rxd = 1'b0;
    tick();
    tick();
    rxd = 1'b1;
    repeat (3 * PER) tick();
    chk("glitch", {61'd0, dv, busy, ferr}, 64'd0);

    // rd coincident with commit
    sb.push_back(32'h0000_0011);
    send_byte(8'h11, 1'b1);
    wait_dv("coin1");
    chk_word("coin1_q");
    sb.push_back(32'h0000_0022);
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    chk("coin_dv_ovf", {62'd0, dv, ovf}, 64'b10);
    chk_word("coin2_q");
    pulse_rd();

    // burst timeout then clean burst
    mode = 1'b1;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    repeat (20 * PER) tick();
    chk("tout_set", {61'd0, tout, dv, busy}, 64'b100);
    pulse_rd();
    chk("tout_rd_clear", {63'd0, tout}, 64'd0);
    sb.push_back(32'h0403_0201);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    wait_dv("tout_next");
    chk_word("tout_next_q");
    pulse_rd();
    mode = 1'b0;

    // reset mid-frame
    sb.push_back(32'h0000_0077);
    send_byte(8'h77, 1'b1);
    wait_dv("pre_rst");
    chk_word("pre_rst_q");
    rxd = 1'b0;
    repeat (30) tick();
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid", {27'd0, q, dv, ovf, ferr, tout, busy}, 64'd0);
    rxd = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    sb.push_back(32'h0000_005C);
    send_byte(8'h5C, 1'b1);
    wait_dv("post_rst");
    chk_word("post_rst_q");
    pulse_rd();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
